// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_HOLD = 1'b1
    } hz_state_e;

    localparam int REG_ZERO = 0;

    // Counter width that never collapses to zero bits for tiny maxima.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_down_counter
// Description : Loadable down-counter that stops at zero, with nonzero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_nonzero
);

    logic [WIDTH-1:0] r_count;

    // A load always wins over the decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count   = r_count;
    assign o_nonzero = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use / mul-div stall and branch-flush control for ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      ID_EX_MemRead_i,
    input  logic [REG_AW-1:0]         ID_EX_Rt_i,
    input  logic [NUM_SRC*REG_AW-1:0] IF_ID_Src_i,
    input  logic [NUM_SRC-1:0]        IF_ID_SrcValid_i,
    input  logic                      ID_UsesMd_i,
    input  logic                      EX_MdStart_i,
    input  logic                      Branch_Taken_i,
    output logic                      PCWrite_o,
    output logic                      IF_IDWrite_o,
    output logic                      ID_EX_Bubble_o,
    output logic                      IF_ID_Flush_o,
    output logic                      Md_Busy_o,
    output logic [CNT_W-1:0]          Stall_Cnt_o
);

    localparam int c_LD_W = cnt_width(LOAD_LAT);
    localparam int c_MD_W = cnt_width(MULDIV_LAT + 1);

    hz_state_e          r_state;
    hz_state_e          w_state_nxt;
    logic [NUM_SRC-1:0] w_src_match;
    logic               w_lu_hit;
    logic               w_ld_load;
    logic [c_LD_W-1:0]  w_ld_cnt;
    logic               w_ld_nz;
    logic [c_MD_W-1:0]  w_md_cnt_unused;
    logic               w_md_nz;
    logic               w_hold;
    logic               w_stall;
    logic [CNT_W-1:0]   r_stall_cnt;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign w_src_match[k] = IF_ID_SrcValid_i[k] &&
                                (IF_ID_Src_i[k*REG_AW +: REG_AW] == ID_EX_Rt_i);
    end

    assign w_lu_hit = ID_EX_MemRead_i && (ID_EX_Rt_i != REG_AW'(REG_ZERO)) && (|w_src_match);

    hazard_down_counter #(.WIDTH(c_LD_W)) u_ld_cnt (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .i_load     (w_ld_load),
        .i_load_val (c_LD_W'(LOAD_LAT - 1)),
        .o_count    (w_ld_cnt),
        .o_nonzero  (w_ld_nz)
    );

    hazard_down_counter #(.WIDTH(c_MD_W)) u_md_cnt (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .i_load     (EX_MdStart_i),
        .i_load_val (c_MD_W'(MULDIV_LAT)),
        .o_count    (w_md_cnt_unused),
        .o_nonzero  (w_md_nz)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The hit cycle itself is the first bubble; LOAD_HOLD supplies the rest.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_load   = 1'b0;
        w_hold      = (r_state == LOAD_HOLD) && w_ld_nz;
        case (r_state)
            IDLE: begin
                if (w_lu_hit && (LOAD_LAT > 1)) begin
                    w_state_nxt = LOAD_HOLD;
                    w_ld_load   = 1'b1;
                end
            end
            LOAD_HOLD: begin
                if (w_ld_cnt == c_LD_W'(1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_stall = rst_n_i && (((r_state == IDLE) && w_lu_hit) || w_hold ||
                              (w_md_nz && ID_UsesMd_i));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign PCWrite_o      = ~w_stall;
    assign IF_IDWrite_o   = ~w_stall;
    assign ID_EX_Bubble_o = w_stall;
    // A branch seen under stall has stale operands, so it must not flush.
    assign IF_ID_Flush_o  = rst_n_i && Branch_Taken_i && !w_stall;
    assign Md_Busy_o      = w_md_nz;
    assign Stall_Cnt_o    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench: three parameterisations against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mem_read;
    logic [4:0]  rt;
    logic [9:0]  src;
    logic [1:0]  valid;
    logic        uses_md;
    logic        md_start;
    logic        br;

    logic        pcw [3];
    logic        ifw [3];
    logic        bub [3];
    logic        fl  [3];
    logic        busy[3];
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic [3:0]  cnt_c;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.LOAD_LAT(1)) u_l1 (
        .clk_i(clk), .rst_n_i(rst_n), .ID_EX_MemRead_i(mem_read), .ID_EX_Rt_i(rt),
        .IF_ID_Src_i(src), .IF_ID_SrcValid_i(valid), .ID_UsesMd_i(uses_md),
        .EX_MdStart_i(md_start), .Branch_Taken_i(br), .PCWrite_o(pcw[0]),
        .IF_IDWrite_o(ifw[0]), .ID_EX_Bubble_o(bub[0]), .IF_ID_Flush_o(fl[0]),
        .Md_Busy_o(busy[0]), .Stall_Cnt_o(cnt_a));

    hazard_ctrl #(.LOAD_LAT(3)) u_l3 (
        .clk_i(clk), .rst_n_i(rst_n), .ID_EX_MemRead_i(mem_read), .ID_EX_Rt_i(rt),
        .IF_ID_Src_i(src), .IF_ID_SrcValid_i(valid), .ID_UsesMd_i(uses_md),
        .EX_MdStart_i(md_start), .Branch_Taken_i(br), .PCWrite_o(pcw[1]),
        .IF_IDWrite_o(ifw[1]), .ID_EX_Bubble_o(bub[1]), .IF_ID_Flush_o(fl[1]),
        .Md_Busy_o(busy[1]), .Stall_Cnt_o(cnt_b));

    hazard_ctrl #(.LOAD_LAT(4), .CNT_W(4)) u_l4 (
        .clk_i(clk), .rst_n_i(rst_n), .ID_EX_MemRead_i(mem_read), .ID_EX_Rt_i(rt),
        .IF_ID_Src_i(src), .IF_ID_SrcValid_i(valid), .ID_UsesMd_i(uses_md),
        .EX_MdStart_i(md_start), .Branch_Taken_i(br), .PCWrite_o(pcw[2]),
        .IF_IDWrite_o(ifw[2]), .ID_EX_Bubble_o(bub[2]), .IF_ID_Flush_o(fl[2]),
        .Md_Busy_o(busy[2]), .Stall_Cnt_o(cnt_c));

    // Reference model: remaining load-stall cycles, remaining busy cycles, stall count.
    int lat [3] = '{1, 3, 4};
    int cmax[3] = '{65535, 65535, 15};
    int ld_left[3];
    int mcnt[3];
    int md_left;

    typedef struct {
        logic       mr;
        logic [4:0] rt;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] v;
        logic       umd;
        logic       br;
        logic       exp_stall;
        logic       exp_flush;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic bit f_hit();
        bit h;
        h = 1'b0;
        if (mem_read && rt != 5'd0) begin
            if (valid[0] && src[4:0] == rt) h = 1'b1;
            if (valid[1] && src[9:5] == rt) h = 1'b1;
        end
        return h;
    endfunction

    function automatic bit f_stall(input int i);
        if (!rst_n) return 1'b0;
        return (ld_left[i] > 0) || f_hit() || (md_left > 0 && uses_md);
    endfunction

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            bit st;
            st = f_stall(i);
            chk($sformatf("m%0d_pcwrite", i), pcw[i], !st);
            chk($sformatf("m%0d_ifidwrite", i), ifw[i], !st);
            chk($sformatf("m%0d_bubble", i), bub[i], st);
            chk($sformatf("m%0d_flush", i), fl[i], rst_n && br && !st);
            chk($sformatf("m%0d_mdbusy", i), busy[i], rst_n && md_left > 0);
            chk($sformatf("m%0d_stallcnt", i), get_cnt(i), mcnt[i]);
        end
    endtask

    task automatic model_update();
        bit hit;
        hit = f_hit();
        if (!rst_n) begin
            ld_left = '{0, 0, 0};
            mcnt    = '{0, 0, 0};
            md_left = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (f_stall(i) && mcnt[i] < cmax[i]) mcnt[i]++;
                if (ld_left[i] > 0) ld_left[i]--;
                else if (hit) ld_left[i] = lat[i] - 1;
            end
            if (md_start) md_left = 4;
            else if (md_left > 0) md_left--;
        end
    endtask

    task automatic apply(input logic mr, input logic [4:0] r, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [1:0] v, input logic umd,
                         input logic mds, input logic b);
        mem_read = mr; rt = r; src = {s1, s0}; valid = v;
        uses_md = umd; md_start = mds; br = b;
        #1;
    endtask

    task automatic clk_edge();
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_pcwrite", i), pcw[i], 1);
            chk($sformatf("rst%0d_ifidwrite", i), ifw[i], 1);
            chk($sformatf("rst%0d_bubble", i), bub[i], 0);
            chk($sformatf("rst%0d_flush", i), fl[i], 0);
            chk($sformatf("rst%0d_mdbusy", i), busy[i], 0);
            chk($sformatf("rst%0d_stallcnt", i), get_cnt(i), 0);
        end
        ld_left = '{0, 0, 0};
        mcnt    = '{0, 0, 0};
        md_left = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; mem_read = 0; rt = '0; src = '0; valid = '0;
        uses_md = 0; md_start = 0; br = 0;
        ld_left = '{0, 0, 0}; mcnt = '{0, 0, 0}; md_left = 0;

        //              mr    rt    s0    s1    v      umd   br    stall flush
        vecs[0] = '{1'b0, 5'd8, 5'd8, 5'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'd8, 5'd8, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 5'd8, 5'd3, 5'd8, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 5'd8, 5'd8, 5'd9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 5'd8, 5'd8, 5'd8, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 5'd8, 5'd8, 5'd8, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();

        // Single-cycle vectors on the LOAD_LAT=1 instance, which holds no load state.
        for (int n = 0; n < 8; n++) begin
            apply(vecs[n].mr, vecs[n].rt, vecs[n].s0, vecs[n].s1, vecs[n].v,
                  vecs[n].umd, 1'b0, vecs[n].br);
            chk($sformatf("vec%0d_pcwrite", n), pcw[0], !vecs[n].exp_stall);
            chk($sformatf("vec%0d_ifidwrite", n), ifw[0], !vecs[n].exp_stall);
            chk($sformatf("vec%0d_bubble", n), bub[0], vecs[n].exp_stall);
            chk($sformatf("vec%0d_flush", n), fl[0], vecs[n].exp_flush);
            clk_edge();
        end

        // LOAD_LAT=1: one bubble, count 1.
        do_reset();
        apply(1, 5'd8, 5'd8, 5'd0, 2'b01, 0, 0, 0);
        chk("l1_hit_bubble", bub[0], 1);
        chk("l1_hit_pcwrite", pcw[0], 0);
        clk_edge();
        apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        chk("l1_after_bubble", bub[0], 0);
        chk("l1_stallcnt", cnt_a, 1);
        clk_edge();

        // LOAD_LAT=3: three consecutive stall cycles.
        do_reset();
        apply(1, 5'd8, 5'd8, 5'd0, 2'b01, 0, 0, 0);
        chk("l3_stall_c0", bub[1], 1);
        clk_edge();
        for (int c = 1; c <= 3; c++) begin
            apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
            chk($sformatf("l3_stall_c%0d", c), bub[1], (c < 3) ? 1 : 0);
            clk_edge();
        end
        chk("l3_stallcnt", cnt_b, 3);

        // Mul/div busy window with and without a dependent ID instruction.
        do_reset();
        apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 1, 0);
        chk("md_c0_busy", busy[0], 0);
        chk("md_c0_bubble", bub[0], 0);
        clk_edge();
        for (int c = 1; c <= 5; c++) begin
            apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 0);
            chk($sformatf("md_c%0d_busy", c), busy[0], (c <= 4) ? 1 : 0);
            chk($sformatf("md_c%0d_bubble", c), bub[0], (c <= 4) ? 1 : 0);
            clk_edge();
        end
        apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 0);
        clk_edge();
        for (int c = 1; c <= 4; c++) begin
            apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
            chk($sformatf("md_nouse_c%0d_busy", c), busy[0], 1);
            chk($sformatf("md_nouse_c%0d_bubble", c), bub[0], 0);
            clk_edge();
        end

        // Reset in the middle of a LOAD_LAT=4 hold with two busy cycles left.
        do_reset();
        apply(1, 5'd8, 5'd8, 5'd0, 2'b01, 0, 1, 0);
        clk_edge();
        apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        clk_edge();
        apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        clk_edge();
        apply(1, 5'd8, 5'd8, 5'd8, 2'b11, 1, 0, 1);
        chk("l4_hold_bubble", bub[2], 1);
        chk("l4_hold_mdbusy", busy[2], 1);
        do_reset();

        // Saturation of the 4-bit counter.
        for (int c = 0; c < 20; c++) begin
            apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 1, 0);
            clk_edge();
        end
        apply(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0);
        chk("l4_cnt_saturated", cnt_c, 15);
        chk("l1_cnt_19", cnt_a, 19);
        clk_edge();

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(63) == 0) begin
                do_reset();
            end else begin
                apply(1'($urandom_range(1)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                      5'($urandom_range(3)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                      1'($urandom_range(7) == 0), 1'($urandom_range(1)));
                clk_edge();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
